// File: rtl/sbox_seq_pkg.sv
// Shared definitions for the sequential SubBytes/InvSubBytes block:
// FSM encoding, byte/counter sizing and the GF(2^8) helper functions
// used by the merged S-box core.
package sbox_seq_pkg;

  localparam int NUM_BYTES = 16;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] LAST_BYTE = 4'd15;

  // Exponent 254: a^254 is the multiplicative inverse in GF(2^8), with 0 -> 0.
  localparam logic [7:0] INV_EXP = 8'hFE;

  // Affine constants of the forward transform and of its inverse.
  localparam logic [7:0] AFF_C     = 8'h63;
  localparam logic [7:0] AFF_INV_C = 8'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    logic [7:0] r;
    r = {a[6:0], 1'b0};
    if (a[7]) begin
      r = r ^ 8'h1B;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Shift-and-add multiplication in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse by square-and-multiply of a^254.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (INV_EXP[i]) begin
        r = gf_mul(r, base);
      end else begin
        r = r;
      end
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  // Forward affine transform applied after inversion (SubBytes).
  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8]
           ^ x[(i + 7) % 8] ^ AFF_C[i];
    end
    return y;
  endfunction

  // Inverse affine transform applied before inversion (InvSubBytes).
  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ AFF_INV_C[i];
    end
    return y;
  endfunction

endpackage

// File: rtl/sbox_subbytes_seq_sbox.sv
// Merged forward/inverse AES S-box. Both directions share one GF(2^8)
// inverter; only the affine stage differs (after the inverter when
// encrypting, before it when decrypting).
module sbox
  import sbox_seq_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       encrypt,
  output logic [7:0] byte_out
);

  logic [7:0] pre_s;
  logic [7:0] inv_s;

  // Select the inverter input, invert, then select the final affine stage.
  always_comb begin
    pre_s    = byte_in;
    inv_s    = 8'h00;
    byte_out = 8'h00;
    if (encrypt) begin
      pre_s = byte_in;
    end else begin
      pre_s = affine_inv(byte_in);
    end
    inv_s = gf_inv(pre_s);
    if (encrypt) begin
      byte_out = affine_fwd(inv_s);
    end else begin
      byte_out = inv_s;
    end
  end

endmodule

// File: rtl/sbox_subbytes_seq.sv
// Sequential SubBytes / InvSubBytes over a 128-bit state, one byte per
// cycle through a single shared S-box core.
// Compile-time option: SBOX_SEQ_PIPE_REG_EN inserts one register stage
// between the S-box output and the working-register write-back (RUN then
// lasts 17 cycles instead of 16). Results are identical either way.
module sbox_subbytes_seq
  import sbox_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_encrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [127:0]       work_r, work_s;
  logic               mode_r, mode_s;
  logic               in_ready_r, in_ready_s;
  logic               out_valid_r, out_valid_s;
  logic [127:0]       out_state_r, out_state_s;
  logic               busy_r, busy_s;

  logic [7:0]         sbox_in_s;
  logic [7:0]         sbox_out_s;

`ifdef SBOX_SEQ_PIPE_REG_EN
  logic [7:0]         pipe_data_r, pipe_data_s;
  logic [CNT_W-1:0]   pipe_idx_r, pipe_idx_s;
  logic               pipe_vld_r, pipe_vld_s;
  logic               rd_act_r, rd_act_s;
`endif

  // The one S-box core, always reading the byte addressed by the counter.
  sbox u_sbox (
    .byte_in  (sbox_in_s),
    .encrypt  (mode_r),
    .byte_out (sbox_out_s)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    work_s      = work_r;
    mode_s      = mode_r;
    out_state_s = out_state_r;
    sbox_in_s   = work_r[{cnt_r, 3'b000} +: 8];
`ifdef SBOX_SEQ_PIPE_REG_EN
    pipe_data_s = pipe_data_r;
    pipe_idx_s  = pipe_idx_r;
    pipe_vld_s  = pipe_vld_r;
    rd_act_s    = rd_act_r;
`endif

    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          work_s  = in_state;
          mode_s  = in_encrypt;
          cnt_s   = {CNT_W{1'b0}};
          state_s = RUN;
`ifdef SBOX_SEQ_PIPE_REG_EN
          rd_act_s   = 1'b1;
          pipe_vld_s = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
`ifdef SBOX_SEQ_PIPE_REG_EN
        // Read side: capture S(byte[cnt]) into the pipe register.
        if (rd_act_r) begin
          pipe_data_s = sbox_out_s;
          pipe_idx_s  = cnt_r;
          pipe_vld_s  = 1'b1;
          if (cnt_r == LAST_BYTE) begin
            rd_act_s = 1'b0;
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end else begin
          pipe_vld_s = 1'b0;
        end
        // Write side: retire the byte read on the previous cycle.
        if (pipe_vld_r) begin
          work_s[{pipe_idx_r, 3'b000} +: 8] = pipe_data_r;
          if (pipe_idx_r == LAST_BYTE) begin
            state_s     = DONE;
            out_state_s = work_s;
            pipe_vld_s  = 1'b0;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
`else
        work_s[{cnt_r, 3'b000} +: 8] = sbox_out_s;
        if (cnt_r == LAST_BYTE) begin
          state_s     = DONE;
          out_state_s = work_s;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
`endif
      end

      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          out_state_s = 128'd0;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s     = IDLE;
        out_state_s = 128'd0;
      end
    endcase

    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
    busy_s      = (state_s != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      work_r      <= 128'd0;
      mode_r      <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_state_r <= 128'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      work_r      <= work_s;
      mode_r      <= mode_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_state_r <= out_state_s;
      busy_r      <= busy_s;
    end
  end

`ifdef SBOX_SEQ_PIPE_REG_EN
  // Pipe stage between the S-box core and the working-register write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_data_r <= 8'h00;
      pipe_idx_r  <= {CNT_W{1'b0}};
      pipe_vld_r  <= 1'b0;
      rd_act_r    <= 1'b0;
    end else begin
      pipe_data_r <= pipe_data_s;
      pipe_idx_r  <= pipe_idx_s;
      pipe_vld_r  <= pipe_vld_s;
      rd_act_r    <= rd_act_s;
    end
  end
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = out_state_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sbox_subbytes_seq.sv
// Scoreboard bench for sbox_subbytes_seq: the driver pushes hand-computed
// expected states on acceptance, a negedge monitor pops and compares on
// every out_valid & out_ready handshake.
module tb_sbox_subbytes_seq;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_encrypt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

`ifdef SBOX_SEQ_PIPE_REG_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  bit lat_pending = 1'b0;
  logic [127:0] exp_q[$];

  sbox_subbytes_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_encrypt (in_encrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency, scoreboard compare, zero output when not valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (lat_pending) begin
          check("latency", 128'(cyc - acc_cyc + 1), 128'(LAT));
          lat_pending = 1'b0;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected none", out_state);
          end else begin
            check("out_state", out_state, exp_q.pop_front());
          end
        end
      end else begin
        check("zero_when_idle", out_state, 128'd0);
      end
    end
  end

  task automatic send(input logic [127:0] st, input logic enc,
                      input logic [127:0] exp, input bit push);
    int guard;
    guard = 0;
    in_state   = st;
    in_encrypt = enc;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    if (push) begin
      exp_q.push_back(exp);
      lat_pending = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [127:0] vi, vo, held;
  int guard;

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_state   = 128'd0;
    in_encrypt = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    @(posedge clk);
    #1;

    // All-zero state, forward.
    send(128'd0, 1'b1, {16{8'h63}}, 1'b1);
    wait_drain();

    // All 0x63, inverse.
    send({16{8'h63}}, 1'b0, 128'd0, 1'b1);
    wait_drain();

    // Byte 0 = 0x53 forward -> 0xED.
    vi = 128'd0;      vi[7:0] = 8'h53;
    vo = {16{8'h63}}; vo[7:0] = 8'hED;
    send(vi, 1'b1, vo, 1'b1);
    wait_drain();

    // Byte 0 = 0xED inverse -> 0x53.
    send(vo, 1'b0, vi, 1'b1);
    wait_drain();

    // Mixed bytes forward, inputs disturbed while running.
    vi = 128'd0;
    vi[63:0] = 64'hAA55_2010_FF53_0100;
    vo = {16{8'h63}};
    vo[63:0] = 64'hACFC_B7CA_16ED_7C63;
    send(vi, 1'b1, vo, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      in_encrypt = ~in_encrypt;
      in_state   = {4{$urandom}};
      @(negedge clk);
      check("run_in_ready_low", 128'(in_ready), 128'd0);
      check("run_busy_high", 128'(busy), 128'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Mixed bytes inverse, with DONE back-pressure for 10 cycles.
    out_ready = 1'b0;
    send(vo, 1'b0, vi, 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    held = out_state;
    check("hold_first_value", held, vi);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_state = {4{$urandom}};
      @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_state", out_state, held);
      check("hold_in_ready_low", 128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset while byte 7 is being processed; the block must vanish.
    send({16{8'h11}}, 1'b1, 128'd0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_out_state", out_state, 128'd0);
    repeat (25) @(negedge clk);
    check("abort_still_idle", 128'(busy), 128'd0);
    @(posedge clk);
    #1;

    // Fresh block after the abort.
    vi = 128'd0;      vi[7:0] = 8'h53;
    vo = {16{8'h63}}; vo[7:0] = 8'hED;
    send(vi, 1'b1, vo, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
